// File: rtl/psg_pkg.sv
// Shared types, volume table and helpers for the PSG channel mixer.
// Build option: PSG_CH_MUTE_EN adds a per-channel mute input.
package psg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CH_A,
    CH_B,
    CH_C,
    SUM
  } psg_state_e;

  localparam logic [1:0] CH_IDX_A = 2'd0;
  localparam logic [1:0] CH_IDX_B = 2'd1;
  localparam logic [1:0] CH_IDX_C = 2'd2;

  // 1.5 dB steps, 31 = full scale
  localparam logic [7:0] VOL_TBL [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,
    8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,
    8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,
    8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128,
    8'd152, 8'd181, 8'd215, 8'd255
  };

  function automatic logic [4:0] level_idx(
    input logic [4:0] amp,
    input logic [4:0] env
  );
    logic [4:0] idx;
    if (amp[4]) begin
      idx = env;
    end else if (amp[3:0] == 4'd0) begin
      idx = 5'd0;
    end else begin
      idx = {amp[3:0], 1'b1};
    end
    return idx;
  endfunction

endpackage

// File: rtl/psg_vol_lut.sv
// Gated logarithmic volume lookup, shared by all three channels.
module psg_vol_lut
  import psg_pkg::*;
(
  input  logic [4:0] idx_i,
  input  logic       gate_i,
  output logic [7:0] vol_o
);

  assign vol_o = gate_i ? VOL_TBL[idx_i] : 8'd0;

endmodule

// File: rtl/psg_chan_mixer.sv
// YM2149 channel mixer: tone/noise gating, amplitude select, volume sum.
// Build option: PSG_CH_MUTE_EN adds the 3-bit mute input.
module psg_chan_mixer
  import psg_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [2:0]       tone,
  input  logic             noise,
  input  logic [5:0]       mix_ctrl,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [4:0]       env,
`ifdef PSG_CH_MUTE_EN
  input  logic [2:0]       mute,
`endif
  output logic [7:0]       snd_a,
  output logic [7:0]       snd_b,
  output logic [7:0]       snd_c,
  output logic [OUT_W-1:0] sound,
  output logic             sample_valid,
  output logic             busy
);

  psg_state_e state_q;

  logic [2:0] tone_q;
  logic       noise_q;
  logic [5:0] mix_q;
  logic [4:0] amp_q [3];
  logic [4:0] env_q;
  logic [7:0] vol_q [3];
`ifdef PSG_CH_MUTE_EN
  logic [2:0] mute_q;
`endif

  logic [1:0] ch;
  logic       gate;
  logic       gate_eff;
  logic [4:0] idx;
  logic [7:0] lut_vol;
  logic [OUT_W-1:0] sum_d;

  always_comb begin
    ch = CH_IDX_A;
    unique case (1'b1)
      state_q == CH_B: ch = CH_IDX_B;
      state_q == CH_C: ch = CH_IDX_C;
      default:         ch = CH_IDX_A;
    endcase
  end

  // A disable bit forces its path open, so 6'h3F yields a plain DAC level
  assign gate = (tone_q[ch] | mix_q[ch])
              & (noise_q | mix_q[3'(ch) + 3'd3]);

`ifdef PSG_CH_MUTE_EN
  assign gate_eff = gate & ~mute_q[ch];
`else
  assign gate_eff = gate;
`endif

  assign idx = level_idx(amp_q[ch], env_q);

  psg_vol_lut u_lut (
    .idx_i  (idx),
    .gate_i (gate_eff),
    .vol_o  (lut_vol)
  );

  assign sum_d = OUT_W'(vol_q[0])
               + OUT_W'(vol_q[1])
               + OUT_W'(vol_q[2]);

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tone_q       <= '0;
      noise_q      <= 1'b0;
      mix_q        <= '0;
      amp_q        <= '{default: '0};
      env_q        <= '0;
      vol_q        <= '{default: '0};
`ifdef PSG_CH_MUTE_EN
      mute_q       <= '0;
`endif
      snd_a        <= '0;
      snd_b        <= '0;
      snd_c        <= '0;
      sound        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cen) begin
            tone_q   <= tone;
            noise_q  <= noise;
            mix_q    <= mix_ctrl;
            amp_q[0] <= amp_a;
            amp_q[1] <= amp_b;
            amp_q[2] <= amp_c;
            env_q    <= env;
`ifdef PSG_CH_MUTE_EN
            mute_q   <= mute;
`endif
            state_q  <= CH_A;
          end
        end
        CH_A: begin
          vol_q[0] <= lut_vol;
          state_q  <= CH_B;
        end
        CH_B: begin
          vol_q[1] <= lut_vol;
          state_q  <= CH_C;
        end
        CH_C: begin
          vol_q[2] <= lut_vol;
          state_q  <= SUM;
        end
        SUM: begin
          snd_a        <= vol_q[0];
          snd_b        <= vol_q[1];
          snd_c        <= vol_q[2];
          sound        <= sum_d;
          sample_valid <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_chan_mixer.sv
// Directed and randomized checks of psg_chan_mixer against a table model.
// Build option: PSG_CH_MUTE_EN enables the mute checks.
module tb_psg_chan_mixer;

  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cen;
  logic [2:0]       tone;
  logic             noise;
  logic [5:0]       mix_ctrl;
  logic [4:0]       amp_a;
  logic [4:0]       amp_b;
  logic [4:0]       amp_c;
  logic [4:0]       env;
  logic [2:0]       mute;
  logic [7:0]       snd_a;
  logic [7:0]       snd_b;
  logic [7:0]       snd_c;
  logic [OUT_W-1:0] sound;
  logic             sample_valid;
  logic             busy;

  int total = 0;
  int bad   = 0;
  int tbl [32];
  int exp_v [3];
  int exp_s;

  always #5 clk = ~clk;

  psg_chan_mixer #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .tone         (tone),
    .noise        (noise),
    .mix_ctrl     (mix_ctrl),
    .amp_a        (amp_a),
    .amp_b        (amp_b),
    .amp_c        (amp_c),
    .env          (env),
`ifdef PSG_CH_MUTE_EN
    .mute         (mute),
`endif
    .snd_a        (snd_a),
    .snd_b        (snd_b),
    .snd_c        (snd_c),
    .sound        (sound),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int chan_model(input int i);
    int amp;
    int lvl;
    bit tone_on;
    bit noise_on;
    bit pass;
    amp = (i == 0) ? int'(amp_a) : (i == 1) ? int'(amp_b) : int'(amp_c);
    tone_on  = !mix_ctrl[i];
    noise_on = !mix_ctrl[i+3];
    pass = (!tone_on || tone[i]) && (!noise_on || noise);
`ifdef PSG_CH_MUTE_EN
    if (mute[i]) pass = 0;
`endif
    if (amp >= 16) lvl = int'(env);
    else if (amp == 0) lvl = 0;
    else lvl = amp * 2 + 1;
    return pass ? tbl[lvl] : 0;
  endfunction

  task automatic model_now();
    for (int i = 0; i < 3; i++) exp_v[i] = chan_model(i);
    exp_s = exp_v[0] + exp_v[1] + exp_v[2];
  endtask

  task automatic set_in(input logic [5:0] m, input logic [2:0] t,
                        input logic n, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c,
                        input logic [4:0] e);
    mix_ctrl = m; tone = t; noise = n;
    amp_a = a; amp_b = b; amp_c = c; env = e;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".snd_a"}, int'(snd_a), exp_v[0]);
    chk({tag, ".snd_b"}, int'(snd_b), exp_v[1]);
    chk({tag, ".snd_c"}, int'(snd_c), exp_v[2]);
    chk({tag, ".sound"}, int'(sound), exp_s);
  endtask

  task automatic do_sample(input string tag, input bit scramble,
                           input bit env_late);
    int lat;
    model_now();
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    if (scramble) begin
      tone = 3'($urandom); noise = 1'($urandom);
      mix_ctrl = 6'($urandom); amp_a = 5'($urandom);
      amp_b = 5'($urandom); amp_c = 5'($urandom);
      mute = 3'($urandom);
    end
    lat = 0;
    while (!sample_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (env_late && lat == 1) env = 5'd31;
    end
    chk({tag, ".latency"}, lat, 4);
    check_outs(tag);
    @(negedge clk);
    chk({tag, ".valid_width"}, int'(sample_valid), 0);
  endtask

  initial begin
    int nval;
    int nbusy;
    for (int i = 0; i < 32; i++)
      tbl[i] = (i == 0) ? 0
             : $rtoi(255.0 * (10.0 ** (-1.5 * (31 - i) / 20.0)) + 0.5);

    rst_n = 1'b0; cen = 1'b0; mute = 3'b000;
    set_in(6'h00, 3'b000, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00);
    repeat (3) @(negedge clk);
    chk("reset.sound", int'(sound), 0);
    chk("reset.snd_a", int'(snd_a), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.valid", int'(sample_valid), 0);
    rst_n = 1'b1;

    set_in(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h0D, 5'h00);
    do_sample("dac", 1'b0, 1'b0);
    chk("dac.sound_const", exp_s, 383);

    set_in(6'h38, 3'b010, 1'b0, 5'h0F, 5'h0F, 5'h0F, 5'h00);
    do_sample("tone_b", 1'b0, 1'b0);
    tone = 3'b111;
    do_sample("tone_all", 1'b0, 1'b0);

    set_in(6'h07, 3'b000, 1'b0, 5'h0F, 5'h0F, 5'h0F, 5'h00);
    do_sample("noise0", 1'b0, 1'b0);
    noise = 1'b1;
    do_sample("noise1", 1'b0, 1'b0);

    set_in(6'h3F, 3'b000, 1'b0, 5'h10, 5'h00, 5'h00, 5'd29);
    do_sample("env_snap", 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("hold.sound", int'(sound), exp_s);

    for (int k = 0; k < 24; k++) begin
      tone = 3'($urandom); noise = 1'($urandom);
      mix_ctrl = 6'($urandom); env = 5'($urandom);
      amp_a = 5'($urandom); amp_b = 5'($urandom);
      amp_c = 5'($urandom);
`ifdef PSG_CH_MUTE_EN
      mute = 3'($urandom);
`endif
      do_sample("rand", 1'b1, 1'b0);
    end

    mute = 3'b000;
    set_in(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h0D, 5'h10, 5'd27);
    model_now();
    @(negedge clk);
    cen = 1'b1;
    nval = 0;
    nbusy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) cen = 1'b0;
      if (k == 2) begin
        cen = 1'b1;
        set_in(6'h00, 3'b000, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00);
      end
      if (k == 3) cen = 1'b0;
      nval += int'(sample_valid);
      nbusy += int'(busy);
    end
    chk("busy_cen.valid_count", nval, 1);
    chk("busy_cen.busy_count", nbusy, 4);
    check_outs("busy_cen");

    set_in(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h0F, 5'h0F, 5'h00);
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.sound", int'(sound), 0);
    chk("rst_mid.snd_a", int'(snd_a), 0);
    chk("rst_mid.busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nval += int'(sample_valid);
    end
    chk("rst_mid.no_valid", nval, 0);
    chk("rst_mid.sound_after", int'(sound), 0);

`ifdef PSG_CH_MUTE_EN
    mute = 3'b001;
    set_in(6'h3F, 3'b000, 1'b0, 5'h0F, 5'h0F, 5'h0F, 5'h00);
    do_sample("mute_a", 1'b0, 1'b0);
    chk("mute_a.sound_const", exp_s, 510);
    mute = 3'b000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
